// File: rtl/dkong_rom_pkg.sv
// Shared constants and helpers for the ROM slot arbiter: id width, idle id, slot-table packing.
package dkong_rom_pkg;

  localparam int unsigned MAX_SLOTS   = 64;
  localparam int unsigned MAX_ID_W    = 8;
  localparam int unsigned MAX_SCHED_W = MAX_SLOTS * MAX_ID_W;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Id width must also encode the idle id (NCH).
  function automatic int unsigned calc_cw(input int unsigned nch);
    return clog2(nch + 1);
  endfunction

  function automatic int unsigned idle_id(input int unsigned nch);
    return nch;
  endfunction

  // Packs ids[k] into bits [k*cw +: cw]; the caller truncates to NSLOT*CW.
  function automatic logic [MAX_SCHED_W-1:0] sched_pack(
    input logic [MAX_SLOTS-1:0][MAX_ID_W-1:0] ids,
    input int unsigned                        nslot,
    input int unsigned                        cw
  );
    logic [MAX_SCHED_W-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_SLOTS; k++) begin
      for (int b = 0; b < MAX_ID_W; b++) begin
        if (k < nslot && b < cw) r[k*cw+b] = ids[k][b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dkong_rom_tagpipe.sv
// RD_LAT-deep {valid, id} shift register that tracks which channel owns each ROM read in flight.
module dkong_rom_tagpipe #(
  parameter int unsigned IW    = 3,
  parameter int unsigned DEPTH = 1
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  input  logic          I_VLD,
  input  logic [IW-1:0] I_ID,
  output logic          O_VLD,
  output logic [IW-1:0] O_ID
);

  logic [DEPTH-1:0]         r_vld;
  logic [DEPTH-1:0][IW-1:0] r_id;

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_vld <= '0;
      r_id  <= '0;
    end else begin
      r_vld[0] <= I_VLD;
      r_id[0]  <= I_ID;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

  assign O_VLD = r_vld[DEPTH-1];
  assign O_ID  = r_id[DEPTH-1];

endmodule

// File: rtl/dkong_rom_slot_arb.sv
// Time-slot arbiter sharing one synchronous ROM port among NCH fetch clients,
// with sync realignment, on-demand channels and per-channel data-valid pulses.
module dkong_rom_slot_arb
  import dkong_rom_pkg::*;
#(
  parameter  int unsigned             AW     = 19,
  parameter  int unsigned             DW     = 8,
  parameter  int unsigned             NCH    = 6,
  parameter  int unsigned             NSLOT  = 16,
  parameter  int unsigned             RD_LAT = 1,
  localparam int unsigned             CW     = calc_cw(NCH),
  localparam int unsigned             SW     = (clog2(NSLOT) > 0) ? clog2(NSLOT) : 1,
  parameter  logic [NSLOT*CW-1:0]     SCHED  = {NSLOT{CW'(NCH)}},
  parameter  logic [NCH-1:0]          MODE   = '0
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic              I_SYNC,
  input  logic [NCH*AW-1:0] I_CH_ADDR,
  input  logic [NCH-1:0]    I_CH_REQ,
  output logic [NCH*DW-1:0] O_CH_DATA,
  output logic [NCH-1:0]    O_CH_VALID,
  output logic [NCH-1:0]    O_CH_PEND,
  output logic [AW-1:0]     O_ROM_ADDR,
  output logic              O_ROM_RD,
  input  logic [DW-1:0]     I_ROM_DATA,
  output logic [SW-1:0]     O_SLOT
);

  logic              r_s1, r_s2;
  logic [SW-1:0]     r_slot, w_slot_d;
  logic [NCH-1:0]    r_pend, w_pend_d;
  logic [AW-1:0]     r_rom_addr, w_sel_addr;
  logic              r_rom_rd;
  logic [NCH*DW-1:0] r_ch_data, w_ch_data_d;
  logic [NCH-1:0]    r_ch_valid, w_ch_valid_d;
  logic              w_rise, w_issue, w_tag_vld;
  logic [CW-1:0]     w_cur_id, w_tag_id;
  logic [NCH-1:0]    w_hit;

  assign w_rise   = r_s1 & ~r_s2;
  assign w_cur_id = SCHED[r_slot*CW +: CW];

  // One-hot decode of the slot owner; the idle id matches no channel.
  always_comb begin
    w_hit      = '0;
    w_sel_addr = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      w_hit[c] = (w_cur_id == CW'(c));
      if (w_hit[c]) w_sel_addr = I_CH_ADDR[c*AW +: AW];
    end
    w_issue  = |(w_hit & (~MODE | r_pend | I_CH_REQ));
    // A request coincident with its own issue keeps the flag set.
    w_pend_d = MODE & (I_CH_REQ | (r_pend & ~(w_hit & {NCH{w_issue}})));
  end

  always_comb begin
    if (w_rise || r_slot == SW'(NSLOT - 1)) w_slot_d = '0;
    else                                    w_slot_d = r_slot + 1'b1;
  end

  dkong_rom_tagpipe #(
    .IW   (CW),
    .DEPTH(RD_LAT)
  ) u_tagpipe (
    .I_CLK(I_CLK),
    .I_RST(I_RST),
    .I_VLD(w_issue),
    .I_ID (w_cur_id),
    .O_VLD(w_tag_vld),
    .O_ID (w_tag_id)
  );

  always_comb begin
    w_ch_data_d  = r_ch_data;
    w_ch_valid_d = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      if (w_tag_vld && w_tag_id == CW'(c)) begin
        w_ch_data_d[c*DW +: DW] = I_ROM_DATA;
        w_ch_valid_d[c]         = 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_slot     <= '0;
      r_pend     <= '0;
      r_rom_addr <= '0;
      r_rom_rd   <= 1'b0;
      r_ch_data  <= '0;
      r_ch_valid <= '0;
    end else begin
      r_s1       <= I_SYNC;
      r_s2       <= r_s1;
      r_slot     <= w_slot_d;
      r_pend     <= w_pend_d;
      r_rom_rd   <= w_issue;
      if (w_issue) r_rom_addr <= w_sel_addr;
      r_ch_data  <= w_ch_data_d;
      r_ch_valid <= w_ch_valid_d;
    end
  end

  assign O_CH_DATA  = r_ch_data;
  assign O_CH_VALID = r_ch_valid;
  assign O_CH_PEND  = r_pend;
  assign O_ROM_ADDR = r_rom_addr;
  assign O_ROM_RD   = r_rom_rd;
  assign O_SLOT     = r_slot;

endmodule

// File: tb/tb_dkong_rom_slot_arb.sv
// Bench for dkong_rom_slot_arb: two instances (RD_LAT 1 with an on-demand channel, RD_LAT 3)
// share stimulus and are checked every cycle against a fetch-queue reference model.
module tb_dkong_rom_slot_arb;

  localparam int AW = 19, DW = 8, NCH = 4, NSLOT = 8, IDLE = 4;
  // slot 7 .. slot 0
  localparam logic [23:0] SCHED_A = {3'd1, 3'd4, 3'd3, 3'd0, 3'd2, 3'd4, 3'd1, 3'd0};
  localparam logic [23:0] SCHED_B = {3'd4, 3'd3, 3'd2, 3'd4, 3'd4, 3'd1, 3'd0, 3'd0};

  logic              clk = 1'b0;
  logic              rst, sync;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    req;

  logic [NCH*DW-1:0] a_data, b_data;
  logic [NCH-1:0]    a_valid, b_valid, a_pend, b_pend;
  logic [AW-1:0]     a_rom_addr, b_rom_addr, b_d1, b_d2;
  logic              a_rom_rd, b_rom_rd;
  logic [2:0]        a_slot, b_slot;
  logic [DW-1:0]     a_rom_data, b_rom_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // ROM returns the low address byte, RD_LAT-1 cycles after the address appears.
  assign a_rom_data = a_rom_addr[7:0];
  always @(posedge clk) begin
    b_d1 <= b_rom_addr;
    b_d2 <= b_d1;
  end
  assign b_rom_data = b_d2[7:0];

  dkong_rom_slot_arb #(
    .AW(AW), .DW(DW), .NCH(NCH), .NSLOT(NSLOT), .RD_LAT(1), .SCHED(SCHED_A), .MODE(4'b1000)
  ) u_dut_a (
    .I_CLK(clk), .I_RST(rst), .I_SYNC(sync), .I_CH_ADDR(ch_addr), .I_CH_REQ(req),
    .O_CH_DATA(a_data), .O_CH_VALID(a_valid), .O_CH_PEND(a_pend), .O_ROM_ADDR(a_rom_addr),
    .O_ROM_RD(a_rom_rd), .I_ROM_DATA(a_rom_data), .O_SLOT(a_slot)
  );

  dkong_rom_slot_arb #(
    .AW(AW), .DW(DW), .NCH(NCH), .NSLOT(NSLOT), .RD_LAT(3), .SCHED(SCHED_B), .MODE(4'b0000)
  ) u_dut_b (
    .I_CLK(clk), .I_RST(rst), .I_SYNC(sync), .I_CH_ADDR(ch_addr), .I_CH_REQ(req),
    .O_CH_DATA(b_data), .O_CH_VALID(b_valid), .O_CH_PEND(b_pend), .O_ROM_ADDR(b_rom_addr),
    .O_ROM_RD(b_rom_rd), .I_ROM_DATA(b_rom_data), .O_SLOT(b_slot)
  );

  // Reference model: each issued fetch is queued with the cycle it must land in.
  typedef struct {int due; int k; int id; logic [7:0] d;} fetch_t;
  fetch_t     fq[$];
  int         sch [2][8] = '{'{0, 1, 4, 2, 0, 3, 4, 1}, '{0, 0, 1, 4, 4, 2, 3, 4}};
  int         lat [2]    = '{1, 3};
  logic [3:0] mode[2]    = '{4'b1000, 4'b0000};
  int         m_slot[2];
  logic [AW-1:0] m_addr[2];
  logic       m_rd[2];
  logic [7:0] m_data[2][4];
  logic [3:0] m_valid[2], m_pend[2];
  bit         m_s1, m_s2;
  int         cyc = 0;

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_slot[k] = 0; m_addr[k] = '0; m_rd[k] = 1'b0; m_valid[k] = '0; m_pend[k] = '0;
      for (int c = 0; c < NCH; c++) m_data[k][c] = '0;
    end
    fq.delete();
    m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  task automatic model_update();
    bit rise, iss;
    int c;
    if (rst) begin
      model_clear();
      cyc++;
      return;
    end
    rise = m_s1 && !m_s2;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = '0;
      for (int i = fq.size() - 1; i >= 0; i--) begin
        if (fq[i].k == k && fq[i].due == cyc) begin
          m_data[k][fq[i].id]  = fq[i].d;
          m_valid[k][fq[i].id] = 1'b1;
          fq.delete(i);
        end
      end
      c   = sch[k][m_slot[k]];
      iss = (c != IDLE) && (!mode[k][c] || m_pend[k][c] || req[c]);
      if (iss) begin
        m_addr[k] = ch_addr[c*AW +: AW];
        m_rd[k]   = 1'b1;
        fq.push_back('{cyc + lat[k], k, c, ch_addr[c*AW +: 8]});
      end else begin
        m_rd[k] = 1'b0;
      end
      for (int ch = 0; ch < NCH; ch++)
        m_pend[k][ch] = mode[k][ch] && (req[ch] || (m_pend[k][ch] && !(iss && c == ch)));
      m_slot[k] = rise ? 0 : (m_slot[k] + 1) % NSLOT;
    end
    m_s2 = m_s1;
    m_s1 = sync;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_inst(input int k, input string n, input logic [2:0] slot,
                          input logic [AW-1:0] addr, input logic rd, input logic [3:0] vld,
                          input logic [3:0] pend, input logic [31:0] data);
    check({n, "_slot"}, slot, m_slot[k]);
    check({n, "_rom_addr"}, addr, m_addr[k]);
    check({n, "_rom_rd"}, rd, m_rd[k]);
    check({n, "_valid"}, vld, m_valid[k]);
    check({n, "_pend"}, pend, m_pend[k]);
    check({n, "_data"}, data, {m_data[k][3], m_data[k][2], m_data[k][1], m_data[k][0]});
  endtask

  task automatic compare_all();
    cmp_inst(0, "a", a_slot, a_rom_addr, a_rom_rd, a_valid, a_pend, a_data);
    cmp_inst(1, "b", b_slot, b_rom_addr, b_rom_rd, b_valid, b_pend, b_data);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst = 1'b1; sync = 1'b0; req = '0;
    ch_addr = {19'h43, 19'h32, 19'h21, 19'h10};
    model_clear();
    step();
    step();
    check("rst_rd", a_rom_rd, 0);
    check("rst_slot", b_slot, 0);
    rst = 1'b0;

    // Schedule and latency (A), consecutive-slot pipeline at RD_LAT=3 (B).
    step();
    check("t1_addr", a_rom_addr, 19'h10);
    check("t1_rd", a_rom_rd, 1);
    ch_addr[0 +: AW] = 19'h55;
    step();
    check("t1_valid0", a_valid, 4'b0001);
    check("t1_data0", a_data[7:0], 8'h10);
    step();
    check("t1_idle_rd", a_rom_rd, 0);
    check("t1_valid1", a_valid, 4'b0010);
    step();
    check("t5_v0", b_valid, 4'b0001);
    check("t5_d0", b_data[7:0], 8'h10);
    step();
    check("t5_v1", b_valid, 4'b0001);
    check("t5_d1", b_data[7:0], 8'h55);
    step();
    check("t5_v2", b_valid, 4'b0010);
    check("t5_d2", b_data[15:8], 8'h21);

    // Sync realignment while at slot 5.
    for (int i = 0; i < NSLOT && m_slot[0] != 5; i++) step();
    check("t2_at5", a_slot, 5);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("t2_slot6", a_slot, 6);
    step();
    check("t2_slot0", a_slot, 0);
    for (int i = 0; i < 4; i++) step();

    // On-demand single request.
    for (int i = 0; i < NSLOT && m_slot[0] != 1; i++) step();
    req = 4'b1000;
    step();
    req = '0;
    check("t3_pend", a_pend[3], 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      cnt += int'(a_valid[3]);
    end
    check("t3_pulses", cnt, 1);
    check("t3_pend_clr", a_pend[3], 0);
    for (int i = 0; i < NSLOT && m_slot[0] != 5; i++) step();
    step();
    check("t3_idle_rd", a_rom_rd, 0);

    // Request coincident with issue.
    for (int i = 0; i < NSLOT && m_slot[0] != 5; i++) step();
    req = 4'b1000;
    step();
    req = '0;
    check("t4_rd", a_rom_rd, 1);
    check("t4_addr", a_rom_addr, ch_addr[3*AW +: AW]);
    check("t4_pend", a_pend[3], 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      cnt += int'(a_valid[3]);
    end
    check("t4_pulses", cnt, 2);
    check("t4_pend_clr", a_pend[3], 0);

    // Reset mid-flight.
    for (int i = 0; i < NSLOT && !a_rom_rd; i++) step();
    check("t6_rd_before", a_rom_rd, 1);
    rst = 1'b1;
    model_clear();
    #1;
    check("t6_rd", a_rom_rd, 0);
    check("t6_addr", a_rom_addr, 0);
    check("t6_data", {a_data, b_data}, 0);
    check("t6_slot", a_slot, 0);
    compare_all();
    step();
    check("t6_novalid", {a_valid, b_valid}, 0);
    step();
    rst = 1'b0;
    check("t6_slot_rel", b_slot, 0);
    step();
    check("t6_slot1", a_slot, 1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(3) == 0) ch_addr[c*AW +: AW] = AW'($urandom);
      req[2:0] = 3'($urandom);
      req[3]   = ($urandom_range(4) == 0);
      sync     = ($urandom_range(11) == 0);
      rst      = ($urandom_range(149) == 0);
      step();
    end
    rst = 1'b0; sync = 1'b0; req = '0;
    for (int i = 0; i < 8; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
